// File: rtl/led_blink_pkg.sv
// led_blink_array shared types and constants.
// Optional sync input is enabled by LED_BLINK_SYNC_EN.
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam int CH_W = 4;

  function automatic int presc_term(
    input int clk_hz,
    input int tick_hz
  );
    return (clk_hz / tick_hz) - 1;
  endfunction

endpackage

// File: rtl/led_blink_if.sv
// Channel write port of led_blink_array.
// Master drives a one-cycle strobe with target and settings.
interface led_blink_if
  import led_blink_pkg::*;
#(
  parameter int HALF_W = 16
) ();

  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  mode_e             wr_mode;
  logic [HALF_W-1:0] wr_half;

  modport master (
    output wr_en,
    output wr_ch,
    output wr_mode,
    output wr_half
  );

  modport slave (
    input wr_en,
    input wr_ch,
    input wr_mode,
    input wr_half
  );

endinterface

// File: rtl/led_blink_channel.sv
// One LED channel: mode, half-period, tick counter, led/busy.
// LED_BLINK_SYNC_EN adds sync_i to realign all blinkers.
module led_blink_channel
  import led_blink_pkg::*;
#(
  parameter int HALF_W   = 16,
  parameter int DEF_HALF = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              wr_i,
  input  mode_e             mode_i,
  input  logic [HALF_W-1:0] half_i,
`ifdef LED_BLINK_SYNC_EN
  input  logic              sync_i,
`endif
  output logic              led_o,
  output logic              busy_o
);

  mode_e             mode_q, mode_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic [HALF_W-1:0] term;
  logic              sync_w;

`ifdef LED_BLINK_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  // half of zero behaves as one
  assign term = (half_q == '0) ? '0 : half_q - 1'b1;

  always_comb begin
    mode_d = mode_q;
    half_d = half_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    busy_d = busy_q;
    if (wr_i) begin
      mode_d = mode_i;
      half_d = half_i;
      cnt_d  = '0;
      led_d  = (mode_i == MODE_ON) ||
               (mode_i == MODE_ONESHOT);
      busy_d = (mode_i == MODE_ONESHOT);
    end else if (sync_w) begin
      cnt_d = '0;
      if (mode_q == MODE_BLINK) led_d = 1'b0;
    end else begin
      unique case (mode_q)
        MODE_OFF: begin
          led_d  = 1'b0;
          busy_d = 1'b0;
          cnt_d  = '0;
        end
        MODE_ON: begin
          led_d  = 1'b1;
          busy_d = 1'b0;
          cnt_d  = '0;
        end
        MODE_BLINK: begin
          if (tick_i) begin
            if (cnt_q == term) begin
              cnt_d = '0;
              led_d = ~led_q;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        MODE_ONESHOT: begin
          if (tick_i) begin
            if (cnt_q == term) begin
              cnt_d  = '0;
              led_d  = 1'b0;
              busy_d = 1'b0;
              mode_d = MODE_OFF;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_BLINK;
      half_q <= HALF_W'(DEF_HALF);
      cnt_q  <= '0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      half_q <= half_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      busy_q <= busy_d;
    end
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/led_blink_array.sv
// Multi-channel LED blinker: shared prescaler, write decoder, channels.
// LED_BLINK_SYNC_EN adds the sync input.
module led_blink_array
  import led_blink_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1000,
  parameter int NUM_CH   = 4,
  parameter int HALF_W   = 16,
  parameter int DEF_HALF = 1000
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
`ifdef LED_BLINK_SYNC_EN
  input  logic              sync,
`endif
  led_blink_if.slave        wr,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic              tick
);

  localparam int TERM = presc_term(CLK_HZ, TICK_HZ);
  localparam int PW   = $clog2(TERM + 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          clr;

`ifdef LED_BLINK_SYNC_EN
  assign clr = sync;
`else
  assign clr = 1'b0;
`endif

  assign tick = (presc_q == PW'(TERM));

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick || clr) presc_d = '0;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic stb;
    assign stb = wr.wr_en && (wr.wr_ch == CH_W'(i));

    led_blink_channel #(
      .HALF_W   (HALF_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk    (CLOCK_50),
      .rst_n  (reset_n),
      .tick_i (tick),
      .wr_i   (stb),
      .mode_i (wr.wr_mode),
      .half_i (wr.wr_half),
`ifdef LED_BLINK_SYNC_EN
      .sync_i (sync),
`endif
      .led_o  (led[i]),
      .busy_o (busy[i])
    );
  end

endmodule
